// File: rtl/tdm_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 4-channel TDM demultiplexer:
//   NUM_CH / SLOT_W  - channel count and width of the slot index
//   tdm_state_e      - frame alignment state (HUNT, LOCKED)
//   SLOT_I0..SLOT_I3 - slot index constants, slot n carries channel n
// ----------------------------------------------------------------------------
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        HUNT,
        LOCKED
    } tdm_state_e;

    localparam logic [SLOT_W-1:0] SLOT_I0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_I1 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_I2 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT_I3 = 2'd3;

endpackage

// File: rtl/tdm_sync_fsm.sv
// ----------------------------------------------------------------------------
// tdm_sync_fsm
// Frame alignment control for the TDM demultiplexer. Owns the HUNT/LOCKED
// state, the slot counter, the missing-marker counter and the sync_err pulse.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_valid, i_sync   beat qualifier and frame marker of the incoming beat
//   o_wr_en           this beat must be stored (combinational, same cycle)
//   o_wr_slot         slot the beat is stored into (combinational)
//   o_frame_done      this beat completes a frame (combinational)
//   o_slot            next slot to be written (registered)
//   o_locked          frame alignment established (registered)
//   o_sync_err        one-cycle pulse: marker seen at slot 1..3 while locked
// ----------------------------------------------------------------------------
module tdm_sync_fsm
    import tdm_pkg::*;
#(
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic              o_wr_en,
    output logic [SLOT_W-1:0] o_wr_slot,
    output logic              o_frame_done,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_locked,
    output logic              o_sync_err
);

    localparam logic [2:0] MissLimit = 3'(MISS_LIMIT);

    tdm_state_e        r_state;
    logic [SLOT_W-1:0] r_slot;
    logic [2:0]        r_miss;
    logic              r_sync_err;

    logic              w_wr_en;
    logic [SLOT_W-1:0] w_wr_slot;
    logic              w_frame_done;
    logic              w_resync;
    logic              w_drop;
    logic [2:0]        w_miss_inc;

    assign w_miss_inc = r_miss + 3'd1;

    // Decode what the current beat does; the datapath needs this on the same edge.
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_slot    = r_slot;
        w_frame_done = 1'b0;
        w_resync     = 1'b0;
        w_drop       = 1'b0;
        if (i_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (i_sync) begin
                        w_wr_en   = 1'b1;
                        w_wr_slot = SLOT_I0;
                    end
                end
                LOCKED: begin
                    if (r_slot == SLOT_I0) begin
                        // Flywheel: a missing marker is tolerated until the limit is hit.
                        if (!i_sync && (w_miss_inc == MissLimit)) begin
                            w_drop = 1'b1;
                        end else begin
                            w_wr_en   = 1'b1;
                            w_wr_slot = SLOT_I0;
                        end
                    end else if (i_sync) begin
                        // Misaligned marker wins over completion, even at slot 3.
                        w_resync  = 1'b1;
                        w_wr_en   = 1'b1;
                        w_wr_slot = SLOT_I0;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_wr_slot    = r_slot;
                        w_frame_done = (r_slot == SLOT_I3);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= HUNT;
            r_slot     <= SLOT_I0;
            r_miss     <= 3'd0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_resync;
            if (i_valid) begin
                unique case (r_state)
                    HUNT: begin
                        if (i_sync) begin
                            r_state <= LOCKED;
                            r_slot  <= SLOT_I1;
                            r_miss  <= 3'd0;
                        end
                    end
                    LOCKED: begin
                        if (w_drop) begin
                            r_state <= HUNT;
                            r_slot  <= SLOT_I0;
                            r_miss  <= 3'd0;
                        end else begin
                            r_slot <= w_wr_slot + 2'd1;
                            if (i_sync) begin
                                r_miss <= 3'd0;
                            end else if (r_slot == SLOT_I0) begin
                                r_miss <= w_miss_inc;
                            end
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign o_wr_en      = w_wr_en;
    assign o_wr_slot    = w_wr_slot;
    assign o_frame_done = w_frame_done;
    assign o_slot       = r_slot;
    assign o_locked     = (r_state == LOCKED);
    assign o_sync_err   = r_sync_err;

endmodule

// File: rtl/tdm_demux_4ch.sv
// ----------------------------------------------------------------------------
// tdm_demux_4ch
// Receive end of the 4-channel TDM path: locks to the frame marker, steers
// each valid beat into its channel and presents a complete frame at once.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_din, i_din_valid   TDM sample and its valid qualifier
//   i_frame_sync         marks the beat as slot 0 (ignored when not valid)
//   o_y0..o_y3           channel samples of the last complete frame
//   o_frame_valid        one-cycle pulse after o_y0..o_y3 take a new frame
//   o_slot               next slot to be written
//   o_locked             frame alignment established
//   o_sync_err           one-cycle pulse on a misaligned frame marker
// ----------------------------------------------------------------------------
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned DATA_W     = 1,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_din_valid,
    input  logic              i_frame_sync,
    output logic [DATA_W-1:0] o_y0,
    output logic [DATA_W-1:0] o_y1,
    output logic [DATA_W-1:0] o_y2,
    output logic [DATA_W-1:0] o_y3,
    output logic              o_frame_valid,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_locked,
    output logic              o_sync_err
);

    logic              w_wr_en;
    logic [SLOT_W-1:0] w_wr_slot;
    logic              w_frame_done;

    // Slot 3 needs no shadow: it goes straight to y3 on the completing edge.
    logic [DATA_W-1:0] r_shadow0;
    logic [DATA_W-1:0] r_shadow1;
    logic [DATA_W-1:0] r_shadow2;
    logic [DATA_W-1:0] r_y0;
    logic [DATA_W-1:0] r_y1;
    logic [DATA_W-1:0] r_y2;
    logic [DATA_W-1:0] r_y3;
    logic              r_frame_valid;

    tdm_sync_fsm #(
        .MISS_LIMIT (MISS_LIMIT)
    ) u_sync_fsm (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_din_valid),
        .i_sync       (i_frame_sync),
        .o_wr_en      (w_wr_en),
        .o_wr_slot    (w_wr_slot),
        .o_frame_done (w_frame_done),
        .o_slot       (o_slot),
        .o_locked     (o_locked),
        .o_sync_err   (o_sync_err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow0 <= '0;
            r_shadow1 <= '0;
            r_shadow2 <= '0;
        end else if (w_wr_en) begin
            unique case (w_wr_slot)
                SLOT_I0: r_shadow0 <= i_din;
                SLOT_I1: r_shadow1 <= i_din;
                SLOT_I2: r_shadow2 <= i_din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_y0 <= r_shadow0;
                r_y1 <= r_shadow1;
                r_y2 <= r_shadow2;
                r_y3 <= i_din;
            end
        end
    end

    assign o_y0          = r_y0;
    assign o_y1          = r_y1;
    assign o_y2          = r_y2;
    assign o_y3          = r_y3;
    assign o_frame_valid = r_frame_valid;

endmodule
